// File: rtl/const_mult_seq.sv
// const_mult_seq
//   Multiplies each accepted operand by a fixed list of NC coefficients and
//   emits one product beat per coefficient. The first beat appears one cycle
//   after accept. A new operand can be taken on the last beat, so there is no
//   bubble between operands. Products use shift-add, not a multiplier.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   operand offered
//   in_data    unsigned operand, DW bits
//   in_ready   operand taken when in_valid & in_ready at a clock edge
//   out_valid  out_data / out_idx / out_last are valid
//   out_ready  consumer takes the current beat
//   out_data   operand * coefficient, OW = DW+CW bits
//   out_idx    coefficient step of the current beat
//   out_last   high on the final step (NC-1)
//   flush      synchronous abort of the operand in flight
//   busy       high while an operand is being stepped through
module const_mult_seq #(
  parameter int unsigned DW = 8,
  parameter int unsigned NC = 4,
  parameter int unsigned CW = 4,
  parameter logic [NC*CW-1:0] COEFS = {4'd9, 4'd7, 4'd3, 4'd1},
  localparam int unsigned OW = DW + CW,
  localparam int unsigned IW = (NC > 1) ? $clog2(NC) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic [IW-1:0] out_idx,
  output logic          out_last,
  input  logic          flush,
  output logic          busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(NC - 1);

  state_t        state, state_n;
  logic [DW-1:0] d_reg, d_n;
  logic [IW-1:0] idx, idx_n;
  logic [OW-1:0] data_n;
  logic          valid_n;

  logic          last_beat;
  logic          accept;
  logic          advance;
  logic [DW-1:0] mul_a;
  logic [IW-1:0] coef_sel;
  logic [CW-1:0] coef;
  logic [OW-1:0] prod;

  assign last_beat = out_valid & (idx == LAST_IDX);
  assign out_last  = last_beat;
  assign out_idx   = idx;
  assign busy      = (state == RUN);

  // The last beat leaving frees the operand register, so a new operand may
  // be taken on that same edge.
  assign in_ready = ~flush & ((state == IDLE) | (out_valid & out_ready & last_beat));
  assign accept   = in_valid & in_ready;
  assign advance  = out_valid & out_ready & ~last_beat;

  // One shared shift-add: either the new operand with the first coefficient,
  // or the held operand with the next coefficient.
  assign mul_a    = accept ? in_data : d_reg;
  assign coef_sel = advance ? idx + 1'b1 : '0;
  assign coef     = COEFS[32'(coef_sel) * CW +: CW];

  always_comb begin
    prod = '0;
    for (int unsigned b = 0; b < CW; b++) begin
      if (coef[b]) prod = prod + (OW'(mul_a) << b);
    end
  end

  always_comb begin
    state_n = state;
    d_n     = d_reg;
    idx_n   = idx;
    data_n  = out_data;
    valid_n = out_valid;
    if (flush) begin
      state_n = IDLE;
      valid_n = 1'b0;
      idx_n   = '0;
    end else if (accept) begin
      state_n = RUN;
      d_n     = in_data;
      idx_n   = '0;
      data_n  = prod;
      valid_n = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (advance) begin
            idx_n  = idx + 1'b1;
            data_n = prod;
          end else if (out_valid & out_ready) begin
            state_n = IDLE;
            valid_n = 1'b0;
            idx_n   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      d_reg     <= '0;
      idx       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      d_reg     <= d_n;
      idx       <= idx_n;
      out_data  <= data_n;
      out_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_const_mult_seq.sv
// Bench for const_mult_seq: a queue model of expected beats for the default
// configuration, checked every cycle, plus literal beat lists per scenario
// and a single-coefficient wide instance.
module tb_const_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last;
  logic        flush = 1'b0, busy;
  logic [7:0]  in_data = '0;
  logic [11:0] out_data;
  logic [1:0]  out_idx;

  // DW=16, NC=1, coefficient 15
  logic        in_valid2 = 1'b0, in_ready2, out_valid2, out_ready2 = 1'b0, out_last2;
  logic        flush2 = 1'b0, busy2;
  logic [15:0] in_data2 = '0;
  logic [19:0] out_data2;
  logic [0:0]  out_idx2;

  const_mult_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
    .out_last(out_last), .flush(flush), .busy(busy)
  );

  const_mult_seq #(.DW(16), .NC(1), .CW(4), .COEFS(4'd15)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_idx(out_idx2),
    .out_last(out_last2), .flush(flush2), .busy(busy2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Model: each accepted operand queues its four products in step order;
  // the head of the queue is the beat that must be on the output.
  typedef struct {
    int unsigned data;
    int unsigned idx;
  } beat_t;
  beat_t q[$];
  int unsigned coefs[4] = '{1, 3, 7, 9};

  always @(posedge clk or negedge rst) begin
    bit acc;
    if (!rst) q.delete();
    else if (flush) q.delete();
    else begin
      acc = in_valid && (q.size() == 0 || (q.size() == 1 && out_ready));
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) for (int i = 0; i < 4; i++) q.push_back('{int'(in_data) * coefs[i], i});
    end
  end

  int unsigned log_data[$];
  int          log_cyc[$];
  int          cyc = 0;

  always @(negedge clk) begin
    bit exp_ready;
    if (!rst) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_busy", busy, 0);
    end else begin
      exp_ready = !flush && (q.size() == 0 || (q.size() == 1 && out_ready));
      chk("in_ready", in_ready, exp_ready);
      chk("busy", busy, q.size() != 0);
      chk("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].data);
        chk("out_idx", out_idx, q[0].idx);
        chk("out_last", out_last, q[0].idx == 3);
      end else begin
        chk("out_last_idle", out_last, 0);
      end
      if (out_valid && out_ready) begin
        log_data.push_back(out_data);
        log_cyc.push_back(cyc);
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string name, input int unsigned exp[], input bit contiguous);
    chk({name, "_count"}, log_data.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_data.size(); i++)
      chk($sformatf("%s_beat%0d", name, i), log_data[i], exp[i]);
    if (contiguous)
      for (int i = 1; i < log_cyc.size(); i++)
        chk($sformatf("%s_gap%0d", name, i), log_cyc[i] - log_cyc[i-1], 1);
    log_data.delete();
    log_cyc.delete();
  endtask

  initial begin
    // reset state
    repeat (2) step();
    #2 rst = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    step();

    // 0xFF through the default coefficients
    in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check_log("ff", '{255, 765, 1785, 2295}, 1'b1);
    chk("ff_idle", busy, 0);

    // stall on beat 1 of operand 5; in_data changes must be ignored
    in_valid = 1'b1; in_data = 8'd5;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd99;
    for (int i = 0; i < 3; i++) begin
      chk("stall_data", out_data, 15);
      chk("stall_idx", out_idx, 1);
      chk("stall_in_ready", in_ready, 0);
      if (i < 2) step();
    end
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    check_log("stall", '{5, 15, 35, 45}, 1'b0);

    // back-to-back operands 2 then 3
    in_valid = 1'b1; in_data = 8'd2;
    step();
    in_data = 8'd3;
    repeat (4) step();
    in_valid = 1'b0;
    repeat (5) step();
    check_log("b2b", '{2, 6, 14, 18, 3, 9, 21, 27}, 1'b1);

    // flush during beat 2 of operand 4, with an operand offered at the same time
    in_valid = 1'b1; in_data = 8'd4;
    step();
    in_valid = 1'b0;
    repeat (2) step();
    chk("pre_flush_data", out_data, 28);
    flush = 1'b1; in_valid = 1'b1; in_data = 8'd77;
    #1 chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    step();
    log_data.delete(); log_cyc.delete();
    in_valid = 1'b1; in_data = 8'd1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    check_log("after_flush", '{1, 3, 7, 9}, 1'b1);

    // reset during beat 1 of operand 7
    in_valid = 1'b1; in_data = 8'd7;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_rst_data", out_data, 21);
    rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_last", out_last, 0);
    step();
    #2 rst = 1'b1;
    #1 chk("rel_in_ready", in_ready, 1);
    log_data.delete(); log_cyc.delete();
    repeat (5) step();
    check_log("after_rst", '{}, 1'b0);

    // wide single-coefficient instance
    in_valid2 = 1'b1; in_data2 = 16'hFFFF; out_ready2 = 1'b1;
    step();
    in_valid2 = 1'b0;
    chk("nc1_valid", out_valid2, 1);
    chk("nc1_data", out_data2, 20'hEFFF1);
    chk("nc1_last", out_last2, 1);
    chk("nc1_idx", out_idx2, 0);
    chk("nc1_busy", busy2, 1);
    step();
    chk("nc1_done_valid", out_valid2, 0);
    chk("nc1_done_busy", busy2, 0);
    chk("nc1_in_ready", in_ready2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
